// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin multiplexer family.
package mux_pkg;

  localparam int MUX_W_DEF = 8;
  localparam int MUX_N_DEF = 4;

  // Modulo-n increment of a channel index; n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping modulo N) wins. Reusable by other arbitrated blocks.
module rr_arb_n #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_oh,
  output logic            any_req
);

  // Rotating priority search starting from ptr.
  always_comb begin : search
    int idx;
    gnt_idx = '0;
    gnt_oh  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        gnt_idx     = SELW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel, W-bit registered multiplexer with round-robin arbitration and
// valid/ready handshakes on every channel and on the output.
// Optional packet locking: define MUX_ARB_LAST_EN to add in_last/out_last;
// a channel that sends a beat without last keeps the grant until its last beat.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter  int W    = MUX_W_DEF,
  parameter  int N    = MUX_N_DEF,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef MUX_ARB_LAST_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);

  logic [SELW-1:0] ptr;
  logic [N-1:0]    req_m;
  logic [SELW-1:0] gnt_idx;
  logic [N-1:0]    gnt_oh;
  logic            any_req;
  logic            accept;

  assign accept = !out_valid || out_ready;

`ifdef MUX_ARB_LAST_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;
  logic [N-1:0]    lock_mask;

  // While locked, only the owning channel may be considered, even when idle.
  always_comb begin
    lock_mask          = '0;
    lock_mask[lock_ch] = 1'b1;
    req_m              = locked ? (in_valid & lock_mask) : in_valid;
  end
`else
  assign req_m = in_valid;
`endif

  rr_arb_n #(.N(N)) u_arb (
    .req     (req_m),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh),
    .any_req (any_req)
  );

  // Only the granted channel sees ready, and never while held in reset.
  assign in_ready = (rst_n && accept) ? gnt_oh : '0;

  // Output register and arbitration pointer; all updates gated by accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef MUX_ARB_LAST_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (accept) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(gnt_idx)*W +: W];
        out_sel   <= gnt_idx;
`ifdef MUX_ARB_LAST_EN
        out_last  <= in_last[gnt_idx];
        if (in_last[gnt_idx]) begin
          locked <= 1'b0;
          ptr    <= SELW'(rr_next(int'(gnt_idx), N));
        end else begin
          locked  <= 1'b1;
          lock_ch <= gnt_idx;
        end
`else
        ptr       <= SELW'(rr_next(int'(gnt_idx), N));
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed, table-driven bench for mux_rr_n (W=8, N=4).
module tb_mux_rr_n;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
`ifdef MUX_ARB_LAST_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mux_rr_n #(.W(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_ARB_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o,
                     input logic [3:0] rdy, input logic ov, input logic [7:0] od, input logic [1:0] os);
    vec_t e;
    e.rst_n = r; e.vld = v; e.data = d; e.ordy = o;
    e.rdy = rdy; e.ov = ov; e.od = od; e.os = os;
    tbl.push_back(e);
  endtask

  // Drive one cycle: check in_ready before the edge, registered outputs after it.
  task automatic step(input int idx, input vec_t e);
    @(negedge clk);
    rst_n     = e.rst_n;
    in_valid  = e.vld;
    in_data   = e.data;
    out_ready = e.ordy;
    #1;
    chk("in_ready", idx, 32'(in_ready), 32'(e.rdy));
    @(posedge clk);
    #1;
    chk("out_valid", idx, 32'(out_valid), 32'(e.ov));
    chk("out_data",  idx, 32'(out_data),  32'(e.od));
    chk("out_sel",   idx, 32'(out_sel),   32'(e.os));
  endtask

  localparam logic [31:0] D  = 32'h13121110;
  localparam logic [31:0] DA = 32'h13A51110;

  initial begin
    rst_n = 1'b0; in_valid = 4'h0; in_data = '0; out_ready = 1'b1;
`ifdef MUX_ARB_LAST_EN
    in_last = 4'hF;
`endif
    // Reset held two cycles with all channels requesting.
    add(0, 4'hF, D, 1, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'hF, D, 1, 4'b0000, 0, 8'h00, 2'd0);
    // Single request on ch2, then idle cycle holds data/sel.
    add(1, 4'b0100, DA, 1, 4'b0100, 1, 8'hA5, 2'd2);
    add(1, 4'b0000, DA, 1, 4'b0000, 0, 8'hA5, 2'd2);
    // Reset again to restart the pointer at 0, then full load.
    add(0, 4'hF, D, 1, 4'b0000, 0, 8'h00, 2'd0);
    add(1, 4'hF, D, 1, 4'b0001, 1, 8'h10, 2'd0);
    add(1, 4'hF, D, 1, 4'b0010, 1, 8'h11, 2'd1);
    add(1, 4'hF, D, 1, 4'b0100, 1, 8'h12, 2'd2);
    add(1, 4'hF, D, 1, 4'b1000, 1, 8'h13, 2'd3);
    add(1, 4'hF, D, 1, 4'b0001, 1, 8'h10, 2'd0);
    add(1, 4'hF, D, 1, 4'b0010, 1, 8'h11, 2'd1);
    // Backpressure for 5 cycles: everything holds.
    for (int i = 0; i < 5; i++) add(1, 4'hF, D, 0, 4'b0000, 1, 8'h11, 2'd1);
    // Release: grant resumes from stored ptr (2), then ch3.
    add(1, 4'hF, D, 1, 4'b0100, 1, 8'h12, 2'd2);
    add(1, 4'hF, D, 1, 4'b1000, 1, 8'h13, 2'd3);
    // Wrap/skip with only ch1 and ch3 requesting.
    add(1, 4'b1010, D, 1, 4'b0010, 1, 8'h11, 2'd1);
    add(1, 4'b1010, D, 1, 4'b1000, 1, 8'h13, 2'd3);
    add(1, 4'b1010, D, 1, 4'b0010, 1, 8'h11, 2'd1);
    // Reset mid-operation while a beat is held under backpressure.
    add(1, 4'hF, D, 0, 4'b0000, 1, 8'h11, 2'd1);
    add(0, 4'hF, D, 0, 4'b0000, 0, 8'h00, 2'd0);

    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

`ifdef MUX_ARB_LAST_EN
    begin
      vec_t e;
      // ch1 three-beat packet with a gap; ch0 must not be granted meanwhile.
      e.rst_n = 1; e.data = 32'h13122110; e.ordy = 1;
      e.vld = 4'b0010; e.rdy = 4'b0010; e.ov = 1; e.od = 8'h21; e.os = 2'd1;
      in_last = 4'b0000; step(100, e); chk("out_last", 100, 32'(out_last), 32'd0);
      e.vld = 4'b0011; e.rdy = 4'b0010;
      step(101, e); chk("out_last", 101, 32'(out_last), 32'd0);
      e.vld = 4'b0001; e.rdy = 4'b0000; e.ov = 0;
      step(102, e); chk("out_last", 102, 32'(out_last), 32'd0);
      e.vld = 4'b0011; e.rdy = 4'b0010; e.ov = 1;
      in_last = 4'b0010; step(103, e); chk("out_last", 103, 32'(out_last), 32'd1);
      e.vld = 4'b0011; e.rdy = 4'b0001; e.od = 8'h10; e.os = 2'd0;
      in_last = 4'b0000; step(104, e); chk("out_last", 104, 32'(out_last), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
